// File: rtl/key_expansion_if.sv
// key_expansion_if -- handshake/bus bundle for the AES-128 key expansion block.
//   start_in, key_in       : request to expand key_in (sampled only when idle)
//   key_ready_in           : downstream accepts the presented round key
//   round_key_out/idx_out  : current round key and its index (0..10)
//   key_valid_out          : round_key_out/round_idx_out valid
//   busy_out, done_out     : not idle / one-cycle completion pulse
//   rd_idx_in, rd_key_out  : round-key bank read port (KEY_EXPANSION_STORE_EN only)
// master = requester/consumer side, slave = the key_expansion block.
interface key_expansion_if #(
  parameter int DATA_WIDTH = 128
);
  logic                  start_in;
  logic [DATA_WIDTH-1:0] key_in;
  logic                  key_ready_in;
  logic [DATA_WIDTH-1:0] round_key_out;
  logic [3:0]            round_idx_out;
  logic                  key_valid_out;
  logic                  busy_out;
  logic                  done_out;
`ifdef KEY_EXPANSION_STORE_EN
  logic [3:0]            rd_idx_in;
  logic [127:0]          rd_key_out;

  modport master (output start_in, key_in, key_ready_in, rd_idx_in,
                  input  round_key_out, round_idx_out, key_valid_out, busy_out, done_out, rd_key_out);
  modport slave  (input  start_in, key_in, key_ready_in, rd_idx_in,
                  output round_key_out, round_idx_out, key_valid_out, busy_out, done_out, rd_key_out);
`else
  modport master (output start_in, key_in, key_ready_in,
                  input  round_key_out, round_idx_out, key_valid_out, busy_out, done_out);
  modport slave  (input  start_in, key_in, key_ready_in,
                  output round_key_out, round_idx_out, key_valid_out, busy_out, done_out);
`endif
endinterface

// File: rtl/key_expansion.sv
// key_expansion -- AES-128 (FIPS-197) round-key generator, one key per cycle.
// Ports: clk (rising edge), rst (synchronous, active-high), bus (key_expansion_if.slave).
// A start in IDLE loads key_in as round key 0; each accepted key (valid & ready)
// advances to the next round key until key 10 is accepted, then DONE pulses
// done_out for one cycle and the block returns to IDLE.
// Optional macro KEY_EXPANSION_STORE_EN adds an 11x128 bank of the presented
// round keys, read through rd_idx_in with a registered rd_key_out (1 cycle).
module key_expansion #(
  parameter int DATA_WIDTH = 128
) (
  input  logic            clk,
  input  logic            rst,
  key_expansion_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] key_q, key_d, next_key;
  logic [3:0]            idx_q, idx_d, rnd;
  logic [31:0]           w0, w1, w2, w3, rot, temp, n0, n1, n2, n3;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // S-box as GF(2^8) inverse (x^254, 0 maps to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Next round key from the one currently presented.
  always_comb begin
    w0   = key_q[127:96];
    w1   = key_q[95:64];
    w2   = key_q[63:32];
    w3   = key_q[31:0];
    rnd  = idx_q + 4'd1;
    rot  = {w3[23:0], w3[31:24]};
    temp = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
           ^ {rcon(rnd), 24'h000000};
    n0   = w0 ^ temp;
    n1   = w1 ^ n0;
    n2   = w2 ^ n1;
    n3   = w3 ^ n2;
    next_key = {n0, n1, n2, n3};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    key_d             = key_q;
    idx_d             = idx_q;
    bus.key_valid_out = 1'b0;
    bus.busy_out      = 1'b1;
    bus.done_out      = 1'b0;
    case (state_q)
      IDLE: begin
        bus.busy_out = 1'b0;
        if (bus.start_in) begin
          state_d = EXPAND;
          key_d   = bus.key_in;
          idx_d   = 4'd0;
        end
      end
      EXPAND: begin
        bus.key_valid_out = 1'b1;
        if (bus.key_ready_in) begin
          if (idx_q == 4'd10) begin
            state_d = DONE;
          end else begin
            key_d = next_key;
            idx_d = idx_q + 4'd1;
          end
        end
      end
      DONE: begin
        bus.done_out = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.round_key_out = key_q;
  assign bus.round_idx_out = idx_q;

`ifdef KEY_EXPANSION_STORE_EN
  logic [127:0] bank [0:10];
  logic [10:0]  written;
  logic [127:0] rd_key_q;

  // Rewriting the same entry while stalled is harmless: the key is held stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= 10; i++) bank[i] <= '0;
      written  <= '0;
      rd_key_q <= '0;
    end else begin
      if (state_q == EXPAND) begin
        bank[idx_q]    <= key_q;
        written[idx_q] <= 1'b1;
      end
      if (bus.rd_idx_in <= 4'd10 && written[bus.rd_idx_in])
        rd_key_q <= bank[bus.rd_idx_in];
      else
        rd_key_q <= '0;
    end
  end

  assign bus.rd_key_out = rd_key_q;
`endif
endmodule

// File: tb/tb_key_expansion.sv
// tb_key_expansion -- scoreboard bench for key_expansion.
// Stimulus pushes the expected round-key sequence into a queue; a monitor pops
// and compares on every accepted key and counts done_out pulses.
module tb_key_expansion;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  key_expansion_if #(.DATA_WIDTH(128)) bus();
  key_expansion #(.DATA_WIDTH(128)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
    bit           chk;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  logic [127:0] fips_tab [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
  logic [127:0] zero_idx1  = 128'h62636363626363636263636362636363;
  logic [127:0] zero_idx10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_seq(input bit zero);
    exp_t e;
    for (int i = 0; i <= 10; i++) begin
      e.idx = 4'(i);
      if (zero) begin
        e.key = (i == 0) ? 128'h0 : (i == 1) ? zero_idx1 : zero_idx10;
        e.chk = (i <= 1) || (i == 10);  // intermediate keys: index order only
      end else begin
        e.key = fips_tab[i];
        e.chk = 1'b1;
      end
      q.push_back(e);
    end
  endtask

  // Monitor: pops one expectation per accepted round key.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.key_valid_out && bus.key_ready_in) begin
        if (q.size() == 0) begin
          chk("unexpected_key", {124'h0, bus.round_idx_out}, 128'hffff);
        end else begin
          e = q.pop_front();
          chk($sformatf("idx_seq%0d", e.idx), {124'h0, bus.round_idx_out}, {124'h0, e.idx});
          if (e.chk) chk($sformatf("key_idx%0d", e.idx), bus.round_key_out, e.key);
        end
      end
      if (bus.done_out) done_cnt++;
    end
  end

  // Leaves the caller at posedge+1 of the edge that sampled start_in.
  task automatic start_key(input logic [127:0] k);
    @(posedge clk); #1;
    bus.start_in = 1'b1;
    bus.key_in   = k;
    @(posedge clk); #1;
    bus.start_in = 1'b0;
  endtask

  // Waits (bounded) for done_out; n = negedges from call to the done cycle.
  task automatic wait_done(input string name, output int n);
    int  d0;
    bit  seen;
    d0   = done_cnt;
    seen = 1'b0;
    n    = 0;
    for (int c = 1; c <= 60 && !seen; c++) begin
      @(negedge clk);
      if (bus.done_out) begin
        seen = 1'b1;
        n    = c;
      end
    end
    chk({name, "_done_seen"}, {127'h0, seen}, 128'h1);
    @(negedge clk);
    chk({name, "_done_one_cycle"}, {127'h0, bus.done_out}, 128'h0);
    chk({name, "_idle_after"}, {127'h0, bus.busy_out}, 128'h0);
    chk({name, "_queue_empty"}, 128'(q.size()), 128'h0);
    chk({name, "_done_count"}, 128'(done_cnt - d0), 128'h1);
  endtask

`ifdef KEY_EXPANSION_STORE_EN
  task automatic rd_chk(input string name, input logic [3:0] idx, input logic [127:0] exp);
    @(posedge clk); #1;
    bus.rd_idx_in = idx;
    @(posedge clk);
    @(negedge clk);
    chk(name, bus.rd_key_out, exp);
  endtask
`endif

  initial begin
    int n, d0;
    bus.start_in     = 1'b0;
    bus.key_in       = '0;
    bus.key_ready_in = 1'b1;
`ifdef KEY_EXPANSION_STORE_EN
    bus.rd_idx_in    = 4'd0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_key", bus.round_key_out, 128'h0);
    chk("rst_idx", {124'h0, bus.round_idx_out}, 128'h0);
    chk("rst_flags", {125'h0, bus.key_valid_out, bus.busy_out, bus.done_out}, 128'h0);
`ifdef KEY_EXPANSION_STORE_EN
    rd_chk("rd_unwritten", 4'd0, 128'h0);
`endif

    // FIPS-197 run, ready held high: 11 valid cycles then done.
    push_seq(1'b0);
    start_key(FIPS_KEY);
    wait_done("fips", n);
    chk("fips_latency", 128'(n), 128'd12);

`ifdef KEY_EXPANSION_STORE_EN
    rd_chk("rd_idx10", 4'd10, fips_tab[10]);
    rd_chk("rd_idx3", 4'd3, fips_tab[3]);
    rd_chk("rd_idx12", 4'd12, 128'h0);
`endif

    // Backpressure: stall 5 cycles while idx3 is presented.
    push_seq(1'b0);
    start_key(FIPS_KEY);
    repeat (3) @(posedge clk);
    #1 bus.key_ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall_key%0d", i), bus.round_key_out, 128'h3d80477d4716fe3e1e237e446d7a883b);
      chk($sformatf("stall_idx%0d", i), {124'h0, bus.round_idx_out}, 128'd3);
      chk($sformatf("stall_valid%0d", i), {127'h0, bus.key_valid_out}, 128'h1);
    end
    @(posedge clk); #1 bus.key_ready_in = 1'b1;
    wait_done("stall", n);

    // Start pulsed with another key at idx2 must be ignored.
    push_seq(1'b0);
    start_key(FIPS_KEY);
    repeat (2) @(posedge clk);
    #1;
    bus.start_in = 1'b1;
    bus.key_in   = 128'h00112233445566778899aabbccddeeff;
    @(posedge clk); #1 bus.start_in = 1'b0;
    wait_done("busy_start", n);
    chk("busy_start_latency", 128'(n), 128'd9);

    // Reset while idx5 is presented: abort, no done pulse.
    push_seq(1'b0);
    start_key(FIPS_KEY);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    q.delete();
    d0 = done_cnt;
    @(negedge clk);
    chk("midrst_key", bus.round_key_out, 128'h0);
    chk("midrst_idx", {124'h0, bus.round_idx_out}, 128'h0);
    chk("midrst_flags", {125'h0, bus.key_valid_out, bus.busy_out, bus.done_out}, 128'h0);
    repeat (15) @(negedge clk);
    chk("midrst_no_done", 128'(done_cnt - d0), 128'h0);

    // All-zero key, also the restart after the aborted run.
    push_seq(1'b1);
    start_key(128'h0);
    wait_done("zero", n);
    chk("zero_latency", 128'(n), 128'd12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/key_expansion.md
KEY_EXPANSION -- requirements
Module: key_expansion

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 128, the state/key width; only 128 is supported.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-004 The block SHALL have port start_in, input, 1 bit, a request to begin expansion of key_in.
REQ-005 The block SHALL have port key_in, input, DATA_WIDTH bits, the cipher key; bits [127:120] are byte 0 and w0 is key_in[127:96].
REQ-006 The block SHALL have port key_ready_in, input, 1 bit, the downstream round stage accepting the current round key.
REQ-007 The block SHALL have port round_key_out, output, DATA_WIDTH bits, the current round key in the same byte order as key_in.
REQ-008 The block SHALL have port round_idx_out, output, 4 bits, the index (0..10) of round_key_out.
REQ-009 The block SHALL have port key_valid_out, output, 1 bit; round_key_out and round_idx_out are valid while it is high.
REQ-010 The block SHALL have port busy_out, output, 1 bit, high outside IDLE.
REQ-011 The block SHALL have port done_out, output, 1 bit, a one-cycle pulse when expansion completes.

Function
REQ-012 The FSM SHALL have states IDLE, EXPAND and DONE.
REQ-013 IDLE SHALL go to EXPAND when start_in=1: key_in is registered, round_key_out = key_in, round_idx_out = 0, and key_valid_out rises on the next cycle.
REQ-014 A handshake SHALL occur on a cycle where key_valid_out=1 and key_ready_in=1.
REQ-015 On a handshake with idx<10, the next round key (FIPS-197 schedule) SHALL be registered, idx incremented, and key_valid_out held high, giving one key per cycle while ready is held high.
REQ-016 Per round, the schedule SHALL be: temp = SubWord(RotWord(w3)) ^ Rcon[idx+1]; w0'=w0^temp, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
REQ-017 Rcon SHALL be 01,02,04,08,10,20,40,80,1B,36 for rounds 1..10, placed in the MSB byte of the word.
REQ-018 The SubWord S-box SHALL be the standard AES S-box, purely combinational (table or GF(2^8) inverse plus affine; free choice).
REQ-019 While key_valid_out=1 and key_ready_in=0, round_key_out and round_idx_out SHALL hold stable.
REQ-020 A handshake at idx=10 SHALL clear key_valid_out and move the FSM to DONE.
REQ-021 DONE SHALL assert done_out for exactly one cycle and then go to IDLE.
REQ-022 start_in while in EXPAND or DONE SHALL be ignored; key_in is sampled only in IDLE.
REQ-023 The total expansion with key_ready_in held high SHALL be 11 valid cycles, with done_out on the cycle after the idx=10 handshake.

Reset
REQ-024 When rst=1 on a clock edge, the FSM SHALL go to IDLE; round_key_out=0, round_idx_out=0, key_valid_out=0, busy_out=0, done_out=0.
REQ-025 rst SHALL take priority over start_in and handshakes; reset mid-expansion SHALL abort with no done_out pulse.

Configuration
REQ-026 With macro KEY_EXPANSION_STORE_EN defined, the block SHALL add input rd_idx_in[3:0] and output rd_key_out[127:0], and an 11x128 bank written with each round key when it is first presented.
REQ-027 With KEY_EXPANSION_STORE_EN defined, rd_key_out SHALL be registered with one-cycle latency, and SHALL be 0 for rd_idx_in>10 or for entries not yet written since reset; reset clears the bank.
REQ-028 Without KEY_EXPANSION_STORE_EN, the store ports and bank SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-029 FIPS-197 case: key 2b7e151628aed2a6abf7158809cf4f3c, start, ready=1 -> idx0 = key, idx1 = a0fafe1788542cb123a339392a6c7605, idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6, done_out one cycle later.
REQ-030 Backpressure: ready=0 for 5 cycles at idx3 -> round_key_out stable at 3d80477d4716fe3e1e237e446d7a883b with idx=3, then resumes.
REQ-031 Mid-run reset: rst=1 at idx5 -> all outputs 0 the next cycle, no done_out, and a new start then begins at idx0.
REQ-032 Busy start: start_in pulsed with a different key at idx2 -> ignored; the sequence matches the original key through idx10.
REQ-033 All-zero key -> idx1 = 62636363626363636263636362636363, idx10 = b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-034 With KEY_EXPANSION_STORE_EN, after the REQ-029 run, rd_idx_in=10 -> rd_key_out = d014f9a8c9ee2589e13f0cc8b6630ca6 one cycle later, and rd_idx_in=12 -> 0.
